fsk_tone_correlator: RTL and testbench

- Sits directly downstream of the sample clock generator in the FSK demodulator. It consumes that block's SAMP, SHIFT and COUNT outputs.
- On each SAMP pulse it captures one ADC sample into an NTAPS-deep history.
- During the following SHIFT cycles it correlates the history against fixed ±1 mark and space tone patterns, one tap per cycle.
- It then decides the received bit and pulses VALID.

---
 rtl/fsk_tone_correlator.sv | 178 +++++++++++++++++
 tb/tb_fsk_tone_correlator.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fsk_tone_correlator.sv
// rtl/fsk_tone_correlator.sv - FSK mark/space tone correlator with per-frame bit decision
// Optional quadrature correlation is enabled by defining FSK_CORR_QUAD_EN.
module fsk_tone_correlator #(
  parameter int               W             = 8,
  parameter int               NTAPS         = 16,
  parameter int               ACC_W         = 16,
  parameter logic [NTAPS-1:0] MARK_PATTERN  = 16'hFFFF,
  parameter logic [NTAPS-1:0] SPACE_PATTERN = 16'hAAAA
`ifdef FSK_CORR_QUAD_EN
  ,
  parameter logic [NTAPS-1:0] MARK_Q_PATTERN  = 16'h0F0F,
  parameter logic [NTAPS-1:0] SPACE_Q_PATTERN = 16'h6666
`endif
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic                SAMP,
  input  logic                SHIFT,
  input  logic [6:0]          COUNT,
  input  logic signed [W-1:0] DATA_IN,
  output logic [ACC_W-1:0]    MARK_MAG,
  output logic [ACC_W-1:0]    SPACE_MAG,
  output logic                BIT_OUT,
  output logic                VALID,
  output logic                OVERRUN
);

  localparam int IDX_W  = $clog2(NTAPS);
  localparam int FILL_W = $clog2(NTAPS + 1);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_DECIDE = 2'd2;
  localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic [1:0]              state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [FILL_W-1:0]       fill_q, fill_d;
  logic signed [W-1:0]     hist_q [NTAPS];
  logic signed [W-1:0]     hist_d [NTAPS];
  logic signed [ACC_W-1:0] mark_acc_q, mark_acc_d, space_acc_q, space_acc_d;
  logic [ACC_W-1:0]        mark_mag_q, mark_mag_d, space_mag_q, space_mag_d;
  logic                    bit_q, bit_d, valid_q, valid_d, overrun_q, overrun_d;
  logic signed [ACC_W-1:0] tap;
  logic [ACC_W-1:0]        mark_new, space_new;
  logic                    step;

  // The most negative accumulator value has no positive twin, so it clamps.
  function automatic logic [ACC_W-1:0] abs_sat(input logic signed [ACC_W-1:0] x);
    if (!x[ACC_W-1]) return x;
    if (x == ACC_MIN) return ACC_MAX;
    return -x;
  endfunction

  assign tap  = {{(ACC_W-W){hist_q[idx_q][W-1]}}, hist_q[idx_q]};
  assign step = !SAMP && (state_q == S_ACCUM) && SHIFT;

`ifdef FSK_CORR_QUAD_EN
  logic signed [ACC_W-1:0] mark_quad_acc_q, mark_quad_acc_d, space_quad_acc_q, space_quad_acc_d;

  function automatic logic [ACC_W-1:0] add_sat(input logic [ACC_W-1:0] a, input logic [ACC_W-1:0] b);
    logic [ACC_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, ACC_MAX}) ? ACC_MAX : s[ACC_W-1:0];
  endfunction

  always_comb begin
    mark_quad_acc_d  = mark_quad_acc_q;
    space_quad_acc_d = space_quad_acc_q;
    if (SAMP) begin
      mark_quad_acc_d  = '0;
      space_quad_acc_d = '0;
    end else if (step) begin
      mark_quad_acc_d  = MARK_Q_PATTERN[idx_q]  ? mark_quad_acc_q + tap  : mark_quad_acc_q - tap;
      space_quad_acc_d = SPACE_Q_PATTERN[idx_q] ? space_quad_acc_q + tap : space_quad_acc_q - tap;
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mark_quad_acc_q  <= '0;
      space_quad_acc_q <= '0;
    end else begin
      mark_quad_acc_q  <= mark_quad_acc_d;
      space_quad_acc_q <= space_quad_acc_d;
    end
  end

  assign mark_new  = add_sat(abs_sat(mark_acc_q), abs_sat(mark_quad_acc_q));
  assign space_new = add_sat(abs_sat(space_acc_q), abs_sat(space_quad_acc_q));
`else
  assign mark_new  = abs_sat(mark_acc_q);
  assign space_new = abs_sat(space_acc_q);
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    fill_d      = fill_q;
    hist_d      = hist_q;
    mark_acc_d  = mark_acc_q;
    space_acc_d = space_acc_q;
    mark_mag_d  = mark_mag_q;
    space_mag_d = space_mag_q;
    bit_d       = bit_q;
    valid_d     = 1'b0;
    overrun_d   = overrun_q;
    if (SAMP) begin
      // A sample arriving mid-frame aborts that frame and restarts on the new history.
      for (int i = NTAPS - 1; i > 0; i--) hist_d[i] = hist_q[i-1];
      hist_d[0] = DATA_IN;
      if (fill_q != FILL_W'(NTAPS)) fill_d = fill_q + 1'b1;
      if (state_q != S_IDLE) overrun_d = 1'b1;
      state_d     = S_ACCUM;
      idx_d       = '0;
      mark_acc_d  = '0;
      space_acc_d = '0;
    end else begin
      case (state_q)
        S_ACCUM: begin
          if (COUNT == 7'd0) overrun_d = 1'b1;
          if (SHIFT) begin
            mark_acc_d  = MARK_PATTERN[idx_q]  ? mark_acc_q + tap  : mark_acc_q - tap;
            space_acc_d = SPACE_PATTERN[idx_q] ? space_acc_q + tap : space_acc_q - tap;
            idx_d       = idx_q + 1'b1;
            if (idx_q == IDX_W'(NTAPS - 1)) state_d = S_DECIDE;
          end
        end
        S_DECIDE: begin
          state_d = S_IDLE;
          if (fill_q == FILL_W'(NTAPS)) begin
            mark_mag_d  = mark_new;
            space_mag_d = space_new;
            if (mark_new > space_new) bit_d = 1'b1;
            else if (space_new > mark_new) bit_d = 1'b0;
            valid_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      fill_q      <= '0;
      for (int i = 0; i < NTAPS; i++) hist_q[i] <= '0;
      mark_acc_q  <= '0;
      space_acc_q <= '0;
      mark_mag_q  <= '0;
      space_mag_q <= '0;
      bit_q       <= 1'b0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      fill_q      <= fill_d;
      hist_q      <= hist_d;
      mark_acc_q  <= mark_acc_d;
      space_acc_q <= space_acc_d;
      mark_mag_q  <= mark_mag_d;
      space_mag_q <= space_mag_d;
      bit_q       <= bit_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign MARK_MAG  = mark_mag_q;
  assign SPACE_MAG = space_mag_q;
  assign BIT_OUT   = bit_q;
  assign VALID     = valid_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_fsk_tone_correlator.sv
// tb/tb_fsk_tone_correlator.sv - directed bench for fsk_tone_correlator
module tb_fsk_tone_correlator;

  logic clk = 1'b0;
  logic rst, samp, shift;
  logic [6:0] count;
  logic signed [7:0] din;
  logic [15:0] mark_mag, space_mag;
  logic bit_out, valid, overrun;
  logic [9:0] sat_mark_mag, sat_space_mag;
  logic sat_bit_out, sat_valid, sat_overrun;

  int checks = 0;
  int errors = 0;
  int v_cnt, v_pos, v_mark, v_space, v_bit;
  int s_mark = -1, s_space = -1, s_bit = -1;
  int r_mark, r_space, r_bit, r_valid, r_ovr;
  int quiet;

  always #5 clk = ~clk;

  fsk_tone_correlator dut (
    .CLOCK(clk), .RESET(rst), .SAMP(samp), .SHIFT(shift), .COUNT(count), .DATA_IN(din),
    .MARK_MAG(mark_mag), .SPACE_MAG(space_mag), .BIT_OUT(bit_out), .VALID(valid), .OVERRUN(overrun)
  );

  fsk_tone_correlator #(.ACC_W(10)) dut_sat (
    .CLOCK(clk), .RESET(rst), .SAMP(samp), .SHIFT(shift), .COUNT(count), .DATA_IN(din),
    .MARK_MAG(sat_mark_mag), .SPACE_MAG(sat_space_mag), .BIT_OUT(sat_bit_out),
    .VALID(sat_valid), .OVERRUN(sat_overrun)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One 127-cycle frame: SAMP at position 0, SHIFT high afterwards except in the gap.
  task automatic run_frame(input logic signed [7:0] s, input int gap_at, input int gap_len,
                           input int extra_at, input int reset_at);
    v_cnt = 0;
    v_pos = -1;
    for (int p = 0; p < 127; p++) begin
      @(negedge clk);
      if (valid) begin
        v_cnt++;
        v_pos   = p;
        v_mark  = int'(mark_mag);
        v_space = int'(space_mag);
        v_bit   = int'(bit_out);
      end
      if (sat_valid) begin
        s_mark  = int'(sat_mark_mag);
        s_space = int'(sat_space_mag);
        s_bit   = int'(sat_bit_out);
      end
      if (p == reset_at + 1) begin
        r_mark  = int'(mark_mag);
        r_space = int'(space_mag);
        r_bit   = int'(bit_out);
        r_valid = int'(valid);
        r_ovr   = int'(overrun);
      end
      rst   = (p == reset_at);
      samp  = (p == 0) || (p == extra_at);
      shift = (p > 0) && !(p >= gap_at && p < gap_at + gap_len);
      count = 7'(p);
      din   = s;
    end
  endtask

  initial begin
    rst = 1'b1; samp = 1'b0; shift = 1'b0; count = 7'd1; din = '0;
    repeat (3) @(negedge clk);
    chk("reset_mark", int'(mark_mag), 0);
    chk("reset_space", int'(space_mag), 0);
    chk("reset_bit", int'(bit_out), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    rst = 1'b0;

    quiet = 0;
    for (int k = 0; k < 15; k++) begin
      run_frame(8'sd10, -1, 0, -1, -1);
      quiet += v_cnt;
    end
    chk("const_no_early_valid", quiet, 0);
    run_frame(8'sd10, -1, 0, -1, -1);
    chk("const_valid_count", v_cnt, 1);
    chk("const_latency", v_pos, 18);
    chk("const_mark", v_mark, 160);
    chk("const_space", v_space, 0);
    chk("const_bit", v_bit, 1);
    chk("const_overrun", int'(overrun), 0);

    for (int k = 0; k < 16; k++) run_frame(8'sd0, -1, 0, -1, -1);
    chk("tie_valid_count", v_cnt, 1);
    chk("tie_mark", v_mark, 0);
    chk("tie_space", v_space, 0);
    chk("tie_bit_held", v_bit, 1);

    for (int k = 0; k < 16; k++) run_frame((k % 2 == 0) ? -8'sd5 : 8'sd5, -1, 0, -1, -1);
    chk("alt_mark", v_mark, 0);
    chk("alt_space", v_space, 80);
    chk("alt_bit", v_bit, 0);

    for (int k = 0; k < 16; k++) run_frame(-8'sd32, -1, 0, -1, -1);
    chk("neg_mark", v_mark, 512);
    chk("sat_mark", s_mark, 511);
    chk("sat_space", s_space, 0);
    chk("sat_bit", s_bit, 1);

    run_frame(8'sd7, -1, 0, 5, -1);
    chk("ovr_valid_count", v_cnt, 1);
    chk("ovr_restart_latency", v_pos, 23);
    chk("ovr_mark", v_mark, 434);
    chk("ovr_space", v_space, 0);
    chk("ovr_bit", v_bit, 1);
    chk("ovr_flag", int'(overrun), 1);
    chk("ovr_flag_sat", int'(sat_overrun), 1);

    run_frame(8'sd7, -1, 0, -1, -1);
    chk("ovr_next_latency", v_pos, 18);
    chk("ovr_next_mark", v_mark, 395);
    chk("ovr_next_space", v_space, 39);
    chk("ovr_sticky", int'(overrun), 1);

    run_frame(8'sd3, -1, 0, -1, 8);
    chk("midrst_mark", r_mark, 0);
    chk("midrst_space", r_space, 0);
    chk("midrst_bit", r_bit, 0);
    chk("midrst_valid", r_valid, 0);
    chk("midrst_overrun", r_ovr, 0);
    chk("midrst_no_valid", v_cnt, 0);

    quiet = 0;
    for (int k = 0; k < 15; k++) begin
      run_frame(8'sd3, -1, 0, -1, -1);
      quiet += v_cnt;
    end
    chk("refill_no_early_valid", quiet, 0);
    run_frame(8'sd3, 6, 3, -1, -1);
    chk("gap_valid_count", v_cnt, 1);
    chk("gap_latency", v_pos, 21);
    chk("gap_mark", v_mark, 48);
    chk("gap_space", v_space, 0);
    chk("gap_bit", v_bit, 1);
    run_frame(8'sd3, -1, 0, -1, -1);
    chk("nogap_latency", v_pos, 18);
    chk("nogap_mark", v_mark, 48);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
